// File: rtl/lcd_spi_rx_decoder_if.sv
// Bus bundle for the LCD SPI receive decoder: the serial draw-side inputs
// and the frame-RAM write port plus pointer/status outputs.
interface lcd_spi_rx_decoder_if;
  logic       SPI_SCLK;
  logic       SPI_MOSI;
  logic       SPI_CS_n;
  logic       SPI_RS;
  logic       Ram_Wr_Sig;
  logic [9:0] Ram_Addr;
  logic [7:0] Ram_Data;
  logic [2:0] Page;
  logic [6:0] Column;
  logic       Disp_On;
  logic       Frame_Done_Sig;
  logic       Bad_Cmd_Sig;

  // Draw side: drives the serial lines, observes the decoder results.
  modport master (
    output SPI_SCLK, SPI_MOSI, SPI_CS_n, SPI_RS,
    input  Ram_Wr_Sig, Ram_Addr, Ram_Data, Page, Column, Disp_On,
           Frame_Done_Sig, Bad_Cmd_Sig
  );

  // Decoder side.
  modport slave (
    input  SPI_SCLK, SPI_MOSI, SPI_CS_n, SPI_RS,
    output Ram_Wr_Sig, Ram_Addr, Ram_Data, Page, Column, Disp_On,
           Frame_Done_Sig, Bad_Cmd_Sig
  );
endinterface

// File: rtl/lcd_spi_rx_decoder.sv
// LCD SPI receive decoder: oversamples a slave SPI link with CLK, assembles
// bytes MSB first, and decodes controller commands (page / column / display
// on-off) or display data bytes that are written into a 1024x8 frame RAM.
module lcd_spi_rx_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PAGE_WRAP   = 0
) (
  input logic                 CLK,
  input logic                 RSTn,
  lcd_spi_rx_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] rs_sync;
  logic                   sclk_d;

  logic       sclk_s, mosi_s, cs_s, rs_s;
  logic       sclk_rise;
  logic       byte_done;

  logic [6:0] shift_q;
  logic [2:0] bit_cnt;
  logic [7:0] byte_q;
  logic       rs_q;

  state_t     state_q, state_d;

  logic [2:0] page_q;
  logic [6:0] col_q;
  logic       disp_q;
  logic       wr_q;
  logic [9:0] addr_q;
  logic [7:0] data_q;
  logic       fd_q;
  logic       bad_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign rs_s   = rs_sync[SYNC_STAGES-1];

  // Rising SCLK counts only while the chip is selected.
  assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  // Input synchronizers, reset to the idle bus levels so release is glitch-free.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      rs_sync   <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SPI_SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.SPI_MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.SPI_CS_n};
      rs_sync   <= {rs_sync[SYNC_STAGES-2:0],   bus.SPI_RS};
      sclk_d    <= sclk_s;
    end
  end

  // Bit assembly; runs in every state so an edge during DECODE is not lost.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shift_q <= '0;
      bit_cnt <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
    end else if (cs_s) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      shift_q <= {shift_q[5:0], mosi_s};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        byte_q <= {shift_q, mosi_s};
        rs_q   <= rs_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a completed byte always gets exactly one DECODE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (byte_done)  state_d = DECODE;
        else if (!cs_s) state_d = SHIFT;
      end
      SHIFT: begin
        if (byte_done)  state_d = DECODE;
        else if (cs_s)  state_d = IDLE;
      end
      DECODE: begin
        state_d = cs_s ? IDLE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte decode: pointer/display updates, RAM write strobe and status pulses.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      page_q <= '0;
      col_q  <= '0;
      disp_q <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      fd_q   <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      fd_q  <= 1'b0;
      bad_q <= 1'b0;
      if (state_q == DECODE) begin
        if (rs_q) begin
          wr_q   <= 1'b1;
          addr_q <= {page_q, col_q};
          data_q <= byte_q;
          fd_q   <= ({page_q, col_q} == 10'd1023);
          col_q  <= col_q + 7'd1;
          if ((col_q == 7'd127) && (PAGE_WRAP != 0)) page_q <= page_q + 3'd1;
        end else begin
          casez (byte_q)
            8'b1011_0???: page_q      <= byte_q[2:0];
            8'b0001_????: col_q[6:4]  <= byte_q[2:0];
            8'b0000_????: col_q[3:0]  <= byte_q[3:0];
            8'hAF:        disp_q      <= 1'b1;
            8'hAE:        disp_q      <= 1'b0;
            default:      bad_q       <= 1'b1;
          endcase
        end
      end
    end
  end

  assign bus.Ram_Wr_Sig     = wr_q;
  assign bus.Ram_Addr       = addr_q;
  assign bus.Ram_Data       = data_q;
  assign bus.Page           = page_q;
  assign bus.Column         = col_q;
  assign bus.Disp_On        = disp_q;
  assign bus.Frame_Done_Sig = fd_q;
  assign bus.Bad_Cmd_Sig    = bad_q;

endmodule

// File: tb/tb_lcd_spi_rx_decoder.sv
// Bench for lcd_spi_rx_decoder: directed SPI byte sequences, expected RAM
// writes and bad-command pulses queued up front and checked by a monitor.
module tb_lcd_spi_rx_decoder;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  lcd_spi_rx_decoder_if bus0 ();
  lcd_spi_rx_decoder_if bus1 ();

  lcd_spi_rx_decoder #(.SYNC_STAGES(2), .PAGE_WRAP(0)) dut0 (
    .CLK  (clk),
    .RSTn (rstn),
    .bus  (bus0.slave)
  );

  lcd_spi_rx_decoder #(.SYNC_STAGES(3), .PAGE_WRAP(1)) dut1 (
    .CLK  (clk),
    .RSTn (rstn),
    .bus  (bus1.slave)
  );

  assign bus1.SPI_SCLK = bus0.SPI_SCLK;
  assign bus1.SPI_MOSI = bus0.SPI_MOSI;
  assign bus1.SPI_CS_n = bus0.SPI_CS_n;
  assign bus1.SPI_RS   = bus0.SPI_RS;

  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    logic [9:0] addr;
    logic [7:0] data;
    bit         fd;
  } ev_t;

  ev_t sb[$];
  ev_t ev;
  int  total = 0;
  int  bad   = 0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endfunction

  function automatic void exp_wr(int addr, int data, bit fd);
    ev_t e;
    e.is_wr = 1'b1;
    e.addr  = addr[9:0];
    e.data  = data[7:0];
    e.fd    = fd;
    sb.push_back(e);
  endfunction

  function automatic void exp_bad();
    ev_t e;
    e.is_wr = 1'b0;
    e.addr  = '0;
    e.data  = '0;
    e.fd    = 1'b0;
    sb.push_back(e);
  endfunction

  task automatic send_bits(input bit rs, input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus0.SPI_MOSI = b[i];
      bus0.SPI_RS   = rs;
      #40 bus0.SPI_SCLK = 1'b1;
      #40 bus0.SPI_SCLK = 1'b0;
    end
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    send_bits(rs, b, 8);
    #120;
  endtask

  // Monitor: every strobe or bad-command pulse must match the next queued event.
  always @(negedge clk) begin
    if (bus0.Ram_Wr_Sig || bus0.Bad_Cmd_Sig) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event wr=%0b bad_cmd=%0b addr=%0d data=%0d required=none",
                 bus0.Ram_Wr_Sig, bus0.Bad_Cmd_Sig, bus0.Ram_Addr, bus0.Ram_Data);
      end else begin
        ev = sb.pop_front();
        chk("event_is_write", int'(bus0.Ram_Wr_Sig), int'(ev.is_wr));
        chk("event_bad_cmd", int'(bus0.Bad_Cmd_Sig), int'(!ev.is_wr));
        if (ev.is_wr) begin
          chk("wr_addr", int'(bus0.Ram_Addr), int'(ev.addr));
          chk("wr_data", int'(bus0.Ram_Data), int'(ev.data));
          chk("frame_done", int'(bus0.Frame_Done_Sig), int'(ev.fd));
        end
      end
    end
    if (bus0.Frame_Done_Sig && !bus0.Ram_Wr_Sig) begin
      total++;
      bad++;
      $display("FAIL frame_done_without_write got=1 exp=0");
    end
  end

  initial begin
    bus0.SPI_SCLK = 1'b0;
    bus0.SPI_MOSI = 1'b0;
    bus0.SPI_CS_n = 1'b1;
    bus0.SPI_RS   = 1'b0;

    // Reset state
    #27;
    chk("rst_page", int'(bus0.Page), 0);
    chk("rst_column", int'(bus0.Column), 0);
    chk("rst_disp", int'(bus0.Disp_On), 0);
    chk("rst_wr", int'(bus0.Ram_Wr_Sig), 0);
    chk("rst_addr", int'(bus0.Ram_Addr), 0);
    chk("rst_data", int'(bus0.Ram_Data), 0);
    chk("rst_frame", int'(bus0.Frame_Done_Sig), 0);
    chk("rst_badcmd", int'(bus0.Bad_Cmd_Sig), 0);
    #20 rstn = 1'b1;
    #40 bus0.SPI_CS_n = 1'b0;
    #80;

    // Page 3, column 0x52, then one data byte to address 466
    send_byte(1'b0, 8'hB3);
    send_byte(1'b0, 8'h15);
    send_byte(1'b0, 8'h02);
    chk("page_b3", int'(bus0.Page), 3);
    chk("column_52", int'(bus0.Column), 'h52);
    exp_wr(466, 'hA5, 1'b0);
    send_byte(1'b1, 8'hA5);
    chk("column_53", int'(bus0.Column), 'h53);

    // Display on/off and unrecognized commands
    send_byte(1'b0, 8'hAF);
    chk("disp_on", int'(bus0.Disp_On), 1);
    send_byte(1'b0, 8'hAE);
    chk("disp_off", int'(bus0.Disp_On), 0);
    exp_bad();
    send_byte(1'b0, 8'hB9);
    chk("page_kept_b9", int'(bus0.Page), 3);
    exp_bad();
    send_byte(1'b0, 8'h40);
    chk("column_kept_40", int'(bus0.Column), 'h53);

    // Partial byte aborted by CS_n, then a full data byte at 3*128+0x53
    send_bits(1'b1, 8'hFF, 5);
    bus0.SPI_CS_n = 1'b1;
    #200;
    bus0.SPI_CS_n = 1'b0;
    #80;
    exp_wr(467, 'h3C, 1'b0);
    send_byte(1'b1, 8'h3C);
    chk("column_54", int'(bus0.Column), 'h54);
    chk("page_after_abort", int'(bus0.Page), 3);

    // Last RAM location: frame done, column wrap, page per PAGE_WRAP
    send_byte(1'b0, 8'hB7);
    send_byte(1'b0, 8'h17);
    send_byte(1'b0, 8'h0F);
    chk("column_127", int'(bus0.Column), 127);
    exp_wr(1023, 'hFF, 1'b1);
    send_byte(1'b1, 8'hFF);
    chk("wrap_column", int'(bus0.Column), 0);
    chk("wrap_page_nowrap", int'(bus0.Page), 7);
    chk("wrap_page_wrap", int'(bus1.Page), 0);

    // Burst of 128 data bytes across page 0
    send_byte(1'b0, 8'hB0);
    send_byte(1'b0, 8'h10);
    send_byte(1'b0, 8'h00);
    for (int i = 0; i < 128; i++) begin
      exp_wr(i, (i ^ 'h5A) & 'hFF, 1'b0);
      send_byte(1'b1, 8'(i ^ 'h5A));
    end
    chk("burst_column", int'(bus0.Column), 0);
    chk("burst_page_nowrap", int'(bus0.Page), 0);
    chk("burst_page_wrap", int'(bus1.Page), 1);

    // Reset in the middle of 0xB5, then a clean 0xB2
    send_byte(1'b0, 8'hAF);
    send_bits(1'b0, 8'hB5, 4);
    #20 rstn = 1'b0;
    #20;
    chk("midrst_page", int'(bus0.Page), 0);
    chk("midrst_disp", int'(bus0.Disp_On), 0);
    rstn = 1'b1;
    #80;
    send_byte(1'b0, 8'hB2);
    chk("after_rst_page", int'(bus0.Page), 2);
    chk("after_rst_page_dut1", int'(bus1.Page), 2);

    #200;
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
